// File: rtl/hot_bit_enc_pkg.sv
// Shared types and helpers for the hot-bit encoder.
// Build option: define HOT_BIT_ENC_MERGE_EN to let new vectors merge into
// the pending set while a scan is in progress.
package hot_bit_enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Index width for a vector of 'depth' bits; never narrower than one bit
   function automatic int idx_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/hot_bit_encoder_lsb.sv
// Combinational lowest-set-bit priority encoder: index and one-hot mask of
// the lowest set bit, plus flags for "any bit set" and "exactly one set".
module lsb_priority_encoder #(
   parameter int DEPTH = 8,
   parameter int IDX_W = 3
)(
   input  logic [DEPTH-1:0] vec,
   output logic [IDX_W-1:0] index,
   output logic [DEPTH-1:0] onehot,
   output logic             found,
   output logic             single
);

   // Scan from the top down so the lowest set bit wins; index is 0 when empty
   always_comb begin
      index = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec[i]) index = IDX_W'(i);
      end
   end

   // Two's-complement trick isolates the lowest set bit; clearing it tests for one bit
   assign onehot = vec & (~vec + DEPTH'(1));
   assign found  = |vec;
   assign single = found && ((vec & (vec - DEPTH'(1))) == '0);

endmodule

// File: rtl/hot_bit_encoder.sv
// hot_bit_encoder: turns a multi-hot vector into a stream of set-bit indices,
// lowest first, one per output handshake.
// Build option HOT_BIT_ENC_MERGE_EN: in_ready stays high while scanning and
// accepted vectors are OR-ed into the pending set.
module hot_bit_encoder
   import hot_bit_enc_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int IDX_W = idx_width(DEPTH)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DEPTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic [IDX_W:0]   pending_cnt,
   output logic             busy
);

   state_t           state;
   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] pend_nxt;
   logic [DEPTH-1:0] low_oh;
   logic [IDX_W-1:0] low_idx;
   logic             found;
   logic             single;
   logic             in_fire;
   logic             out_fire;

   function automatic logic [IDX_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) c += {{IDX_W{1'b0}}, v[i]};
      return c;
   endfunction

   lsb_priority_encoder #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_lsb (
      .vec    (pending),
      .index  (low_idx),
      .onehot (low_oh),
      .found  (found),
      .single (single)
   );

`ifdef HOT_BIT_ENC_MERGE_EN
   assign in_ready = 1'b1;
`else
   assign in_ready = (state == IDLE);
`endif

   // All outputs derive from registered state; nothing flows from the inputs
   assign out_valid   = (state == SCAN);
   assign out_index   = low_idx;
   assign out_last    = out_valid && single;
   assign pending_cnt = popcount(pending);
   assign busy        = found;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Retire the issued bit first, then merge any new vector, so a re-set bit survives
   always_comb begin
      pend_nxt = pending;
      if (out_fire) pend_nxt = pend_nxt & ~low_oh;
      if (in_fire)  pend_nxt = pend_nxt | in_vec;
   end

   // State follows the pending set: scanning whenever any bit remains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         pending <= pend_nxt;
         state   <= (pend_nxt != '0) ? SCAN : IDLE;
      end
   end

endmodule
